// File: rtl/case_conv_pkg.sv
// Shared encodings for the case-converting two-requester byte arbiter:
// conversion modes, arbiter FSM states and the default packet terminator.
package case_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_UPPER    = 2'b01,
    MODE_LOWER    = 2'b10,
    MODE_PASS_ALT = 2'b11
  } conv_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

  localparam logic [7:0] CASE_BIT_MASK = 8'h20;

  function automatic logic in_range(input logic [7:0] b,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/case_conv_arb_if.sv
// Bundle of the requester, downstream and mode/counter signals of case_conv_arb.
// Handshake: a byte moves on a rising edge exactly when its valid and ready are
// both high; valid never waits on ready, and ready may depend on valid.
interface case_conv_arb_if #(
  parameter int CNT_W = 16
);

  logic [1:0]       mode;
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_src;
  logic             out_ready;
  logic [CNT_W-1:0] conv_count;

  modport slave (
    input  mode,
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready,
    output out_valid, out_data, out_src,
    input  out_ready,
    output conv_count
  );

  modport master (
    output mode,
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready,
    input  out_valid, out_data, out_src,
    output out_ready,
    input  conv_count
  );

endinterface

// File: rtl/case_conv_byte.sv
// Combinational ASCII case conversion of one byte; flags when the value changed.
module case_conv_byte
  import case_conv_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte,
  output logic       o_changed
);

  always_comb begin
    o_byte = i_byte;
    case (conv_mode_t'(i_mode))
      MODE_UPPER: if (in_range(i_byte, 8'h61, 8'h7A)) o_byte = i_byte & ~CASE_BIT_MASK;
      MODE_LOWER: if (in_range(i_byte, 8'h41, 8'h5A)) o_byte = i_byte | CASE_BIT_MASK;
      default:    o_byte = i_byte;
    endcase
    o_changed = (o_byte != i_byte);
  end

endmodule

// File: rtl/case_conv_arb.sv
// Round-robin packet arbiter between two byte requesters feeding a one-deep
// output register, with per-byte case conversion and a saturating change counter.
module case_conv_arb
  import case_conv_pkg::*;
#(
  parameter logic [7:0] EOL_BYTE = EOL_DEFAULT,
  parameter int         CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  case_conv_arb_if.slave  bus,
  output arb_state_t      o_dbg_state
);

  arb_state_t       r_state;
  logic             r_ptr;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_src;
  logic [CNT_W-1:0] r_conv_count;

  logic             w_slot_free;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_accept;
  logic [7:0]       w_in_byte;
  logic [7:0]       w_conv_byte;
  logic             w_changed;
  logic             w_cnt_max;

  // The output register can take a new byte when empty or draining this cycle.
  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_ready0    = !reset && (r_state == ST_GRANT0) && w_slot_free;
  assign w_ready1    = !reset && (r_state == ST_GRANT1) && w_slot_free;
  assign w_acc0      = w_ready0 && bus.req0_valid;
  assign w_acc1      = w_ready1 && bus.req1_valid;
  assign w_accept    = w_acc0 || w_acc1;
  assign w_in_byte   = w_acc1 ? bus.req1_data : bus.req0_data;
  assign w_cnt_max   = &r_conv_count;

  case_conv_byte u_conv (
    .i_mode    (bus.mode),
    .i_byte    (w_in_byte),
    .o_byte    (w_conv_byte),
    .o_changed (w_changed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_src    <= 1'b0;
      r_conv_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_conv_byte;
        r_out_src   <= w_acc1;
        if (w_changed && !w_cnt_max) begin
          r_conv_count <= r_conv_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.req0_valid && (!bus.req1_valid || !r_ptr)) begin
            r_state <= ST_GRANT0;
          end else if (bus.req1_valid) begin
            r_state <= ST_GRANT1;
          end
        end
        // The terminator is matched on the raw byte, before conversion.
        ST_GRANT0: begin
          if (w_acc0 && (bus.req0_data == EOL_BYTE)) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b1;
          end
        end
        ST_GRANT1: begin
          if (w_acc1 && (bus.req1_data == EOL_BYTE)) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_src    = r_out_src;
  assign bus.conv_count = r_conv_count;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/case_conv_arb.md
CASE_CONV_ARB -- requirements
Module: case_conv_arb

Interface
REQ-001 Parameter EOL_BYTE, default 8'h0A, is the packet-terminator byte that releases a grant.
REQ-002 Parameter CNT_W, default 16, is the width of the conversion counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 mode  input  2  conversion mode: 00 pass, 01 to-upper, 10 to-lower, 11 pass.
REQ-006 req0_valid  input  1  requester 0 presents a byte.
REQ-007 req0_data  input  8  requester 0 byte.
REQ-008 req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-009 req1_valid  input  1  requester 1 presents a byte.
REQ-010 req1_data  input  8  requester 1 byte.
REQ-011 req1_ready  output  1  requester 1 byte accepted this cycle when high with req1_valid.
REQ-012 out_valid  output  1  out_data holds a converted byte.
REQ-013 out_data  output  8  converted byte.
REQ-014 out_src  output  1  requester index of out_data.
REQ-015 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-016 conv_count  output  CNT_W  number of bytes whose value was changed by conversion.

Function
REQ-017 FSM states: IDLE, GRANT0, GRANT1.
REQ-018 IDLE: no ready asserted; if any reqN_valid, move to GRANTn next cycle, n chosen round-robin.
REQ-019 Round-robin: priority pointer starts at requester 0; when both valid, grant goes to the pointer; single valid wins regardless.
REQ-020 GRANTn: reqn_ready = (!out_valid || out_ready); the other ready held 0.
REQ-021 An accepted byte equal to EOL_BYTE returns FSM to IDLE next cycle and sets pointer to the other requester.
REQ-022 An accepted byte appears on out_data with out_valid=1 and out_src=n on the next cycle (latency 1).
REQ-023 out_valid stays 1 and out_data/out_src stay stable until out_valid && out_ready, or until a new byte is accepted in the same cycle.
REQ-024 Simultaneous drain and accept: the new byte replaces the old one with no bubble (full throughput).
REQ-025 To-upper: bytes 0x61..0x7A have bit 5 cleared; all other bytes unchanged.
REQ-026 To-lower: bytes 0x41..0x5A have bit 5 set; all other bytes unchanged.
REQ-027 mode is sampled in the acceptance cycle; a mode change mid-packet applies to later bytes only.
REQ-028 conv_count increments by 1 per accepted byte whose output differs from its input, and saturates at all-ones.
REQ-029 EOL_BYTE itself passes through converted per mode and is delivered like any other byte.
REQ-030 Requester valid dropping mid-packet keeps the grant (no timeout); the other requester waits.

Reset
REQ-031 When reset is high at a clock edge:
  - FSM goes to IDLE and the pointer to requester 0.
  - out_valid, out_data, out_src and conv_count go to 0.
  - Both ready outputs are 0.
REQ-032 Reset mid-packet discards the in-flight output byte and any grant; no byte is accepted in the reset cycle.

Structure
REQ-033 Mode encodings, FSM state encodings and the EOL default go in shared package case_conv_pkg.
REQ-034 The byte conversion is the combinational sub-module case_conv_byte (inputs mode and byte; outputs converted byte and changed flag).

Verification
REQ-035 Case conversion with back-to-back acceptance:
  - Stimulus: mode=01; req0 sends 0x68,0x69,0x0A; out_ready=1.
  - Required response: out_data 0x48,0x49,0x0A on consecutive cycles with out_src=0; conv_count=2.
REQ-036 Round-robin arbitration:
  - Stimulus: both requesters continuously valid, each packet 0x41,0x0A; mode=00.
  - Required response: grants alternate 0,1,0,1 per packet; conv_count stays 0.
REQ-037 Downstream backpressure:
  - Stimulus: out_ready=0 for 5 cycles during a req1 packet.
  - Required response: out_data held stable; req1_ready=0 after the first byte; no byte is lost or duplicated.
REQ-038 Mode switch mid-packet:
  - Stimulus: mode=10 on 0x51, then mode=01 on 0x51.
  - Required response: outputs 0x71 then 0x51; conv_count=1.
REQ-039 Reset mid-packet:
  - Stimulus: assert reset during GRANT0 with out_valid=1.
  - Required response: next cycle out_valid=0, both readies 0, conv_count=0; the following packet from req0 is granted first.
REQ-040 Counter saturation:
  - Stimulus: preload conv_count near its maximum with CNT_W=4; send 20 lowercase bytes with mode=01.
  - Required response: conv_count stops at 4'hF.
